// File: rtl/ps2_keycode_source.sv
// ps2_keycode_source: PS/2 set-2 keyboard front end producing a {valid, ascii} key stream.
// Ports: clk        system clock
//        reset      synchronous active-low reset
//        ps2_clk    PS/2 clock pin (asynchronous)
//        ps2_data   PS/2 data pin (asynchronous)
//        keystrobe  consumer acknowledge level; clears keycode[7] on the next cycle
//        keycode    {valid, ascii[6:0]}; the last ascii is kept after the valid bit clears
//        frame_err  one-cycle pulse on parity error, stop-bit error or timeout abort
// Optional: define PS2_ARROW_KEYS_EN to map E0-prefixed arrow keys onto w/s/a/d.
module ps2_keycode_source #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       keystrobe,
    output logic [7:0] keycode,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_filt, data_filt;
    logic [FW-1:0] clk_cnt, data_cnt;
    logic          fe;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_ok;
    logic [TW-1:0] tcnt;
    logic          byte_valid;
    logic [7:0]    byte_q;
    logic          brk, ext;
    logic [6:0]    base_ascii, ext_ascii, ascii;

    // Synchronise, then only follow a line after FILTER_LEN consecutive differing samples.
    // fe is raised in the same cycle the filtered clock drops to 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_filt  <= 1'b1;
            data_filt <= 1'b1;
            clk_cnt   <= '0;
            data_cnt  <= '0;
            fe        <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            fe        <= 1'b0;
            if (clk_sync[1] == clk_filt)
                clk_cnt <= '0;
            else if (clk_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                clk_cnt  <= '0;
                fe       <= clk_filt;
            end else
                clk_cnt <= clk_cnt + FW'(1);
            if (data_sync[1] == data_filt)
                data_cnt <= '0;
            else if (data_cnt == FW'(FILTER_LEN - 1)) begin
                data_filt <= data_sync[1];
                data_cnt  <= '0;
            end else
                data_cnt <= data_cnt + FW'(1);
        end
    end

    // Frame receiver; the timeout counter saturates and only aborts a frame in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_ok  <= 1'b0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            byte_q     <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fe) begin
                tcnt <= '0;
                case (state)
                    IDLE: if (!data_filt) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        shift   <= {data_filt, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        parity_ok <= ^{shift, data_filt};
                        state     <= STOP;
                    end
                    default: begin
                        byte_valid <= parity_ok & data_filt;
                        frame_err  <= ~(parity_ok & data_filt);
                        byte_q     <= shift;
                        state      <= IDLE;
                    end
                endcase
            end else begin
                if (tcnt != TW'(TIMEOUT)) tcnt <= tcnt + TW'(1);
                if (tcnt == TW'(TIMEOUT) && state != IDLE) begin
                    state     <= IDLE;
                    frame_err <= 1'b1;
                end
            end
        end
    end

    // Zero means "no translation"; none of the mapped ASCII codes is zero.
    always_comb begin
        base_ascii = byte_q == 8'h1D ? 7'h77 :
                     byte_q == 8'h1B ? 7'h73 :
                     byte_q == 8'h1C ? 7'h61 :
                     byte_q == 8'h23 ? 7'h64 :
                     byte_q == 8'h29 ? 7'h20 :
                     byte_q == 8'h2D ? 7'h72 :
                     byte_q == 8'h4D ? 7'h70 : 7'h00;
`ifdef PS2_ARROW_KEYS_EN
        ext_ascii  = byte_q == 8'h75 ? 7'h77 :
                     byte_q == 8'h72 ? 7'h73 :
                     byte_q == 8'h6B ? 7'h61 :
                     byte_q == 8'h74 ? 7'h64 : 7'h00;
`else
        ext_ascii  = 7'h00;
`endif
        ascii      = brk ? 7'h00 : ext ? ext_ascii : base_ascii;
    end

    // Prefix tracking and handshake; a new key load overrides a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            brk     <= 1'b0;
            ext     <= 1'b0;
            keycode <= 8'h00;
        end else begin
            if (keycode[7] && keystrobe) keycode[7] <= 1'b0;
            if (byte_valid) begin
                if (byte_q == 8'hE0)
                    ext <= 1'b1;
                else if (byte_q == 8'hF0)
                    brk <= 1'b1;
                else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (ascii != 7'h00) keycode <= {1'b1, ascii};
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_keycode_source.sv
// tb_ps2_keycode_source: table-driven checks of the PS/2 keycode source.
module tb_ps2_keycode_source;
    localparam int TO = 1000;
    localparam int H  = 20;
`ifdef PS2_ARROW_KEYS_EN
    localparam logic [7:0] UP_KC = 8'hF7;
`else
    localparam logic [7:0] UP_KC = 8'hE4;
`endif

    typedef struct {
        logic [7:0] code;
        logic       flip;
        logic       ks;
        logic [7:0] exp_kc;
        int         exp_err;
        int         exp_vc;   // cycles keycode[7] is high during the frame; negative = unchecked
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       keystrobe = 1'b0;
    logic [7:0] keycode;
    logic       frame_err;
    int         pass_cnt = 0;
    int         total = 0;
    int         errs = 0;
    int         vcyc = 0;
    vec_t       vecs[12];

    ps2_keycode_source #(.FILTER_LEN(4), .TIMEOUT(TO)) dut (
        .clk(clk),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .keystrobe(keystrobe),
        .keycode(keycode),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (keycode[7] === 1'b1) vcyc++;
        if (frame_err === 1'b1) errs++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        @(posedge clk);
        errs = 0;
        vcyc = 0;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Sends the first nbits of a frame: start, 8 data LSB first, odd parity (optionally flipped), stop.
    task automatic send(input logic [7:0] b, input logic flip, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            cyc(H);
            ps2_clk = 1'b0;
            cyc(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic run(input int idx);
        keystrobe = vecs[idx].ks;
        clr();
        send(vecs[idx].code, vecs[idx].flip, 11);
        cyc(40);
        chk($sformatf("vec%0d keycode", idx), int'(keycode), int'(vecs[idx].exp_kc));
        chk($sformatf("vec%0d frame_err", idx), errs, vecs[idx].exp_err);
        if (vecs[idx].exp_vc >= 0) chk($sformatf("vec%0d valid_cycles", idx), vcyc, vecs[idx].exp_vc);
    endtask

    initial begin
        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 8'h61, 0, 1};
        vecs[1]  = '{8'hF0, 1'b0, 1'b1, 8'h61, 0, 0};
        vecs[2]  = '{8'h1D, 1'b0, 1'b1, 8'h61, 0, 0};
        vecs[3]  = '{8'h1B, 1'b0, 1'b0, 8'hF3, 0, -1};
        vecs[4]  = '{8'h23, 1'b1, 1'b0, 8'hF3, 1, -1};
        vecs[5]  = '{8'h23, 1'b0, 1'b0, 8'hE4, 0, -1};
        vecs[6]  = '{8'hE0, 1'b0, 1'b0, 8'hE4, 0, -1};
        vecs[7]  = '{8'h75, 1'b0, 1'b0, UP_KC, 0, -1};
        vecs[8]  = '{8'h1B, 1'b0, 1'b0, 8'hF3, 0, -1};
        vecs[9]  = '{8'h2D, 1'b0, 1'b1, 8'h72, 0, -1};
        vecs[10] = '{8'h12, 1'b0, 1'b0, 8'h72, 0, 0};
        vecs[11] = '{8'h4D, 1'b0, 1'b0, 8'hF0, 0, -1};

        cyc(2);
        chk("reset keycode", int'(keycode), 8'h00);
        chk("reset frame_err", int'(frame_err), 0);
        reset = 1'b1;

        clr();
        send(8'h1D, 1'b0, 11);
        cyc(40);
        chk("w keycode", int'(keycode), 8'hF7);
        chk("w frame_err", errs, 0);
        cyc(200);
        chk("w held", int'(keycode), 8'hF7);
        keystrobe = 1'b1;
        cyc(1);
        keystrobe = 1'b0;
        chk("strobe clear", int'(keycode), 8'h77);

        for (int i = 0; i < 5; i++) run(i);

        keystrobe = 1'b0;
        clr();
        send(8'h23, 1'b0, 4);
        cyc(TO + 200);
        chk("timeout frame_err", errs, 1);
        chk("timeout keycode", int'(keycode), 8'hF3);

        for (int i = 5; i < 12; i++) run(i);

        keystrobe = 1'b0;
        clr();
        send(8'h1D, 1'b0, 6);
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        chk("midframe reset keycode", int'(keycode), 8'h00);
        send(8'h29, 1'b0, 11);
        cyc(40);
        chk("space keycode", int'(keycode), 8'hA0);
        chk("space frame_err", errs, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
